fifo_read_port: RTL and testbench
=================================

// Module: fifo_read_port
// PURPOSE
//  Read-side output stage of the async FIFO, in the read clock domain, downstream of read_pointer.
//  Consumes read_pointer's registered empty flag and the memory's combinational read data
//  (rdata = mem[raddr], same cycle), and drives read_pointer's inc.
//  Presents the FIFO as a first-word-fall-through valid/ready stream with a 2-entry skid buffer.
//  Sustains 1 word/cycle with no combinational path from m_ready to rinc.
// PARAMETERS
//  DATA_WIDTH  8   width of FIFO words and m_data
//  CNT_WIDTH   16  width of the delivered-beat counter
// PORTS
//  clk       in   1           read-domain clock
//  rst_n     in   1           asynchronous active-low reset
//  empty     in   1           registered empty flag from read_pointer
//  rdata     in   DATA_WIDTH  memory read data for the current raddr (valid same cycle)
//  rinc      out  1           read increment to read_pointer (its inc input)
//  m_valid   out  1           output word valid
//  m_data    out  DATA_WIDTH  output word (head of skid buffer)
//  m_ready   in   1           downstream accept
//  buf_count out  2           skid buffer occupancy, 0..2
//  beat_cnt  out  CNT_WIDTH   words accepted downstream; wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset, asynchronous: buf_count=0, m_valid=0, m_data=0, beat_cnt=0, both entries=0.
//    rinc=0 while in reset, because empty=1 and buf_count=0.
//  Fetch: rinc = ~empty & (buf_count < 2). Purely combinational from registered signals.
//    push = rinc. On push, rdata is captured at the clock edge ending that cycle.
//  Pop: pop = m_valid & m_ready. m_valid = (buf_count != 0). m_data = entry0, registered.
//  Buffer update per edge:
//    cnt0, push       -> entry0 = rdata; cnt = 1
//    cnt1, push, ~pop -> entry1 = rdata; cnt = 2
//    cnt1, push, pop  -> entry0 = rdata; cnt = 1
//    cnt1, ~push, pop -> cnt = 0; entry0 keeps its value, don't-care
//    cnt2, pop        -> entry0 = entry1; cnt = 1 (push impossible at cnt2)
//    no push, no pop  -> hold
//  Latency: empty falls in cycle t, so rinc=1 in cycle t and m_valid=1 in cycle t+1 with that word.
//  Throughput: with m_ready held high, the steady state is cnt=1, push+pop every cycle, 1 word/cycle.
//  Backpressure: m_ready=0 fills the buffer to 2, then rinc=0.
//    m_data/m_valid must stay stable until accepted.
//  Ordering: words leave in exactly the order they were pushed. No duplication or loss.
//  beat_cnt increments by 1 on every pop. From 2^CNT_WIDTH-1 it wraps to 0.
//  empty asserting while words are buffered: rinc drops the same cycle; buffered words still drain.
//  Reset mid-operation: buffered words are discarded. read_pointer shares rst_n, so the whole
//    read side restarts coherently. Outputs take their reset values immediately.
//  buf_count never exceeds 2. rinc is never high when empty=1.
// TESTING
//  T1 Reset: drive rst_n=0 mid-stream with cnt=2 -> m_valid=0, buf_count=0, beat_cnt=0, rinc=0
//     asynchronously, before the next clk edge.
//  T2 Single word: FIFO holds 0xA5, m_ready=1 -> rinc one cycle, m_valid one cycle later,
//     m_data=0xA5, beat_cnt=1.
//  T3 Stream: 16 words 0x00..0x0F, m_ready=1 -> 16 consecutive m_valid cycles, in-order data,
//     buf_count stays 1.
//  T4 Backpressure: 8 words, m_ready=0 for 10 cycles -> exactly 2 rinc pulses, buf_count=2,
//     m_data=0x00 stable. After release, 8 words arrive in order with no gaps.
//  T5 Toggle: m_ready alternates 1/0 and empty toggles randomly for 1000 cycles
//     -> scoreboard order matches, buf_count<=2, no rinc while empty=1.
//  T6 Wrap: CNT_WIDTH=4, 18 accepted beats -> beat_cnt=2.

Source files
------------

// File: rtl/fifo_read_port.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_port
// Purpose  : First-word-fall-through read stage of the async FIFO, 2-entry skid
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_port #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            buf_count,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
  logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic                  push;
  logic                  pop;

  // Fetch decision uses only registered state, keeping m_ready off the rinc path.
  assign rinc      = ~empty & (cnt_q < 2'd2);
  assign push      = rinc;
  assign m_valid   = (cnt_q != 2'd0);
  assign pop       = m_valid & m_ready;
  assign m_data    = entry0_q;
  assign buf_count = cnt_q;
  assign beat_cnt  = beat_q;

  always_comb begin
    cnt_d    = cnt_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    beat_d   = beat_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    case (cnt_q)
      2'd0: begin
        if (push) begin
          entry0_d = rdata;
          cnt_d    = 2'd1;
        end
      end
      2'd1: begin
        if (push && !pop) begin
          entry1_d = rdata;
          cnt_d    = 2'd2;
        end else if (push && pop) begin
          entry0_d = rdata;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          entry0_d = entry1_q;
          cnt_d    = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 2'd0;
      entry0_q <= '0;
      entry1_q <= '0;
      beat_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      beat_q   <= beat_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_port
// Purpose  : Self-checking bench: vector table, directed sequences, random run
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_port;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int BEAT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          empty = 1'b1;
  logic          m_ready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] m_data;
  logic          rinc;
  logic          m_valid;
  logic [1:0]    buf_count;
  logic [CW-1:0] beat_cnt;

  fifo_read_port #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .rdata(rdata), .rinc(rinc),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .buf_count(buf_count), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // Source FIFO contents, skid-buffer contents and accepted-beat total.
  logic [7:0] src[$];
  logic [7:0] bq[$];
  int         beat_m;
  bit         hold;
  int         n_pass;
  int         n_total;
  bit         s_rinc, s_valid;
  logic [1:0] s_cnt;
  logic [7:0] s_data;

  typedef struct {
    bit         rdy;
    bit         hold;
    bit         e_rinc;
    bit         e_valid;
    logic [1:0] e_cnt;
    logic [7:0] e_data;
    bit         chk_data;
    logic [3:0] e_beat;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // One read-domain cycle: drive, sample, compare with the model, advance the model.
  task automatic cycle(input bit rdy);
    bit exp_rinc;
    @(negedge clk);
    m_ready = rdy;
    empty   = (src.size() == 0) || hold;
    rdata   = (src.size() != 0) ? src[0] : 8'h00;
    #1;
    s_rinc  = rinc;
    s_valid = m_valid;
    s_cnt   = buf_count;
    s_data  = m_data;
    exp_rinc = !empty && (bq.size() < 2);
    chk("rinc", rinc, exp_rinc);
    chk("m_valid", m_valid, bq.size() != 0);
    chk("buf_count", buf_count, bq.size());
    chk("beat_cnt", beat_cnt, beat_m % BEAT_MOD);
    if (bq.size() != 0) chk("m_data", m_data, bq[0]);
    if (bq.size() != 0 && rdy) begin
      void'(bq.pop_front());
      beat_m++;
    end
    if (exp_rinc) bq.push_back(src.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, nv, rp;
    logic [7:0] nxt, exp_next;

    n_pass = 0; n_total = 0; beat_m = 0; hold = 1'b0;
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 4'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h10, 1'b1, 4'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h10, 1'b1, 4'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'h10, 1'b1, 4'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h11, 1'b1, 4'd1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h11, 1'b1, 4'd1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h12, 1'b1, 4'd2};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'd3};

    // Power-on reset, with read_pointer reporting empty.
    rst_n = 1'b0;
    empty = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset rinc", rinc, 0);
    chk("reset m_valid", m_valid, 0);
    chk("reset buf_count", buf_count, 0);
    chk("reset beat_cnt", beat_cnt, 0);
    chk("reset m_data", m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: fill, stall on empty, drain.
    src.push_back(8'h10); src.push_back(8'h11); src.push_back(8'h12);
    for (int i = 0; i < 8; i++) begin
      hold = tbl[i].hold;
      cycle(tbl[i].rdy);
      chk($sformatf("tbl%0d rinc", i), s_rinc, tbl[i].e_rinc);
      chk($sformatf("tbl%0d m_valid", i), s_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d buf_count", i), s_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d beat_cnt", i), beat_cnt, tbl[i].e_beat);
      if (tbl[i].chk_data) chk($sformatf("tbl%0d m_data", i), s_data, tbl[i].e_data);
    end
    hold = 1'b0;

    // Single word: one-cycle fetch-to-valid latency.
    src.push_back(8'hA5);
    cycle(1'b1);
    chk("single rinc", s_rinc, 1);
    chk("single m_valid early", s_valid, 0);
    cycle(1'b1);
    chk("single m_valid", s_valid, 1);
    chk("single m_data", s_data, 8'hA5);
    cycle(1'b1);
    chk("single beat_cnt", beat_cnt, 4);

    // Stream of 16 words with the sink always ready.
    for (int w = 0; w < 16; w++) src.push_back(w[7:0]);
    nv = 0; first = -1; last = -1; exp_next = 8'h00;
    for (int c = 0; c < 18; c++) begin
      cycle(1'b1);
      if (s_valid) begin
        if (first < 0) first = c;
        last = c;
        nv++;
        chk("stream order", s_data, exp_next);
        chk("stream buf_count", s_cnt, 1);
        exp_next++;
      end
    end
    chk("stream beats", nv, 16);
    chk("stream contiguous", last - first, 15);

    // Backpressure: 10 stalled cycles then release.
    for (int w = 0; w < 8; w++) src.push_back(w[7:0]);
    rp = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0);
      if (s_rinc) rp++;
      if (s_valid) chk("bp m_data stable", s_data, 8'h00);
    end
    chk("bp rinc pulses", rp, 2);
    chk("bp buf_count", s_cnt, 2);
    nv = 0; first = -1; last = -1; exp_next = 8'h00;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1);
      if (s_valid) begin
        if (first < 0) first = c;
        last = c;
        nv++;
        chk("bp order", s_data, exp_next);
        exp_next++;
      end
    end
    chk("bp beats", nv, 8);
    chk("bp contiguous", last - first, 7);

    // Asynchronous reset while the buffer is full.
    src.push_back(8'h77); src.push_back(8'h78); src.push_back(8'h79);
    repeat (3) cycle(1'b0);
    chk("pre-reset buf_count", s_cnt, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    empty = 1'b1;
    #1;
    chk("async rinc", rinc, 0);
    chk("async m_valid", m_valid, 0);
    chk("async buf_count", buf_count, 0);
    chk("async beat_cnt", beat_cnt, 0);
    chk("async m_data", m_data, 0);
    src.delete(); bq.delete(); beat_m = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Counter wrap: 18 beats on a 4-bit counter.
    for (int w = 0; w < 18; w++) src.push_back(8'hC0 + w[7:0]);
    repeat (20) cycle(1'b1);
    chk("wrap beat_cnt", beat_cnt, 2);

    // Random: alternating ready, random empty gating and random refills.
    nxt = 8'h40; exp_next = 8'h40;
    for (int c = 0; c < 1000; c++) begin
      hold = ($urandom_range(0, 3) == 0);
      if (src.size() < 4 && $urandom_range(0, 1) == 1) begin
        src.push_back(nxt);
        nxt++;
      end
      cycle(c[0] == 1'b0);
      chk("rand buf_count bound", s_cnt <= 2, 1);
      if (s_valid && c[0] == 1'b0) begin
        chk("rand order", s_data, exp_next);
        exp_next++;
      end
    end
    hold = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1);
      if (s_valid) begin
        chk("rand drain order", s_data, exp_next);
        exp_next++;
      end
    end
    chk("rand drained", s_valid, 0);
    chk("rand no loss", exp_next, nxt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
